// File: rtl/dna_code_pkg.sv
// Shared definitions for the DNA-code receive path: LLR type, slicer state
// encoding and the hard-decision rule used by both the streaming packer and
// the legacy combinational slicer.
package dna_code_pkg;

  localparam int DEFAULT_LLR_W = 32;

  typedef logic signed [DEFAULT_LLR_W-1:0] llr_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } slice_state_e;

  // Positive LLR means "0 is more likely"; zero carries no information and
  // is resolved to 1.
  function automatic logic llr_hard_bit(input llr_t llr);
    return (llr > 0) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/llr_slice_packer_if.sv
// Stream bundle for llr_slice_packer: input beat handshake plus packed
// output word handshake. The packer uses the slave view, its driver the
// master view.
interface llr_slice_packer_if #(
  parameter int LLR_W     = 32,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 32
);
  localparam int LEN_W = $clog2(BLOCK_LEN + 1);

  logic                            in_valid;
  logic                            in_ready;
  logic [LANES-1:0][LLR_W-1:0]     in_llr;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [BLOCK_LEN-1:0]            out_bits;
  logic [BLOCK_LEN-1:0]            out_erase;
  logic [LEN_W-1:0]                out_len;
  logic                            out_last;

  modport master (
    output in_valid, in_llr, in_last, out_ready,
    input  in_ready, out_valid, out_bits, out_erase, out_len, out_last
  );

  modport slave (
    input  in_valid, in_llr, in_last, out_ready,
    output in_ready, out_valid, out_bits, out_erase, out_len, out_last
  );

endinterface

// File: rtl/llr_lane_slice.sv
// Single-lane combinational slice: hard decision, magnitude and erasure
// flag for one signed LLR against an unsigned threshold.
module llr_lane_slice
  import dna_code_pkg::*;
#(
  parameter int LLR_W = DEFAULT_LLR_W
) (
  input  logic signed [LLR_W-1:0] llr,
  input  logic        [LLR_W-1:0] thr,
  output logic                    hard_bit,
  output logic                    erase
);

  logic [LLR_W-1:0] mag;

  // The shared package rule is used whenever the widths line up; other
  // widths apply the same rule directly (negative or zero slices to 1).
  if (LLR_W == DEFAULT_LLR_W) begin : g_pkg_rule
    assign hard_bit = llr_hard_bit(llr);
  end else begin : g_local_rule
    assign hard_bit = llr[LLR_W-1] | (llr == '0);
  end

  // Magnitude in LLR_W unsigned bits; the most-negative input wraps to
  // exactly 2^(LLR_W-1), which is representable unsigned, so no saturation.
  always_comb begin
    mag = llr[LLR_W-1] ? $unsigned(-llr) : $unsigned(llr);
  end

  assign erase = (mag < thr);

endmodule

// File: rtl/llr_slice_packer.sv
// Streaming LLR hard-decision slicer and packer. Collects LANES LLRs per
// beat into BLOCK_LEN-bit words of hard decisions plus erasure flags.
// Optional feature macro: LLR_SLICE_ERASE_CNT_EN adds per-word erasure
// count (out_erase_cnt) and a saturating running total (erase_total).
module llr_slice_packer
  import dna_code_pkg::*;
#(
  parameter int LLR_W     = 32,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  llr_slice_packer_if.slave                bus,
  input  logic [LLR_W-1:0]                 erase_thr
`ifdef LLR_SLICE_ERASE_CNT_EN
  ,
  output logic [$clog2(BLOCK_LEN+1)-1:0]   out_erase_cnt,
  output logic [31:0]                      erase_total
`endif
);

  localparam int BEATS  = BLOCK_LEN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEN_W  = $clog2(BLOCK_LEN + 1);

  slice_state_e           state_q, state_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BLOCK_LEN-1:0]   bits_q, bits_d;
  logic [BLOCK_LEN-1:0]   erase_q, erase_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   last_q, last_d;
  logic [LLR_W-1:0]       thr_q, thr_d;
  logic [LLR_W-1:0]       thr_eff;
  logic [LANES-1:0]       lane_bits;
  logic [LANES-1:0]       lane_erase;
`ifdef LLR_SLICE_ERASE_CNT_EN
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            total_q, total_d;
  logic [32:0]            total_sum;
`endif

  // First beat of a word uses the live threshold; later beats use the copy
  // latched on that first beat so mid-word changes have no effect.
  assign thr_eff = (beat_cnt_q == '0) ? erase_thr : thr_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    llr_lane_slice #(.LLR_W(LLR_W)) u_lane (
      .llr      (bus.in_llr[g]),
      .thr      (thr_eff),
      .hard_bit (lane_bits[g]),
      .erase    (lane_erase[g])
    );
  end

  // Next-state logic: fill the word beat by beat, then hold it until the
  // downstream handshake clears the registers for the next word.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    bits_d     = bits_q;
    erase_d    = erase_q;
    len_d      = len_q;
    last_d     = last_q;
    thr_d      = thr_q;
`ifdef LLR_SLICE_ERASE_CNT_EN
    cnt_d      = cnt_q;
    total_d    = total_q;
    total_sum  = {1'b0, total_q} + 33'(cnt_q);
`endif
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          bits_d[int'(beat_cnt_q)*LANES +: LANES]  = lane_bits;
          erase_d[int'(beat_cnt_q)*LANES +: LANES] = lane_erase;
          if (beat_cnt_q == '0) begin
            thr_d = erase_thr;
          end
          if ((int'(beat_cnt_q) == BEATS - 1) || bus.in_last) begin
            state_d    = HOLD;
            beat_cnt_d = '0;
            len_d      = LEN_W'((int'(beat_cnt_q) + 1) * LANES);
            last_d     = bus.in_last;
`ifdef LLR_SLICE_ERASE_CNT_EN
            cnt_d = '0;
            for (int k = 0; k < BLOCK_LEN; k++) begin
              cnt_d = cnt_d + LEN_W'(erase_d[k]);
            end
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d    = FILL;
          beat_cnt_d = '0;
          bits_d     = '0;
          erase_d    = '0;
          len_d      = '0;
          last_d     = 1'b0;
`ifdef LLR_SLICE_ERASE_CNT_EN
          cnt_d   = '0;
          total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and word registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      beat_cnt_q <= '0;
      bits_q     <= '0;
      erase_q    <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      thr_q      <= '0;
`ifdef LLR_SLICE_ERASE_CNT_EN
      cnt_q      <= '0;
      total_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      bits_q     <= bits_d;
      erase_q    <= erase_d;
      len_q      <= len_d;
      last_q     <= last_d;
      thr_q      <= thr_d;
`ifdef LLR_SLICE_ERASE_CNT_EN
      cnt_q      <= cnt_d;
      total_q    <= total_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_bits  = bits_q;
  assign bus.out_erase = erase_q;
  assign bus.out_len   = len_q;
  assign bus.out_last  = last_q;
`ifdef LLR_SLICE_ERASE_CNT_EN
  assign out_erase_cnt = cnt_q;
  assign erase_total   = total_q;
`endif

endmodule
